imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate sign-extender.
- Decodes every RV32/RV64 base immediate format: I, S, B, J, U and CSR zimm.
- Extends the immediate to XLEN and flags illegal selector codes.
- Sits between the decode stage and the execute stage. Uses a valid/ready handshake with a skid buffer, so backpressure from execute never drops or duplicates an immediate.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_WIDTH, 5, width of the sideband tag carried alongside each immediate (typically rd index).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_valid  input  1  upstream has a valid instruction.
- o_ready  output  1  block can accept an instruction this cycle.
- i_instr  input  32  full instruction word; bits [6:0] ignored.
- i_ImmSrc  input  3  immediate format selector.
- i_tag  input  TAG_WIDTH  sideband, passed through unchanged.
- o_valid  output  1  o_ImmExt/o_tag/o_illegal are valid.
- i_ready  input  1  downstream accepts the output this cycle.
- o_ImmExt  output  XLEN  extended immediate.
- o_tag  output  TAG_WIDTH  tag matching o_ImmExt.
- o_illegal  output  1  i_ImmSrc was a reserved code.

Behaviour:
- Clock and reset:
  - One clock.
  - i_rst_n low asynchronously clears all state.
  - While in reset: o_valid=0, o_ImmExt=0, o_tag=0, o_illegal=0, skid empty, o_ready=0.
  - o_ready goes 1 on the first rising edge after i_rst_n deasserts.
- Decode function, combinational from i_instr; s() = sign-extend to XLEN from instr[31], z() = zero-extend:
  - 000 I: s(instr[31:20])
  - 001 S: s({instr[31:25],instr[11:7]})
  - 010 B: s({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
  - 011 J: s({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
  - 100 U: s({instr[31:12],12'b0}); upper bits replicate instr[31] when XLEN=64.
  - 101 Z: z(instr[19:15])
  - 110/111: result 0, o_illegal=1 for that entry.
- Handshakes:
  - Input handshake fires when i_valid & o_ready.
  - Output handshake fires when o_valid & i_ready.
- Output register:
  - Latency is exactly 1 cycle from input handshake to o_valid when the output register is empty or draining.
  - o_ImmExt, o_tag and o_illegal hold stable while o_valid & !i_ready.
- Skid buffer (one entry):
  - If an input fires while the output register is valid and not draining, the decoded entry goes to the skid.
  - o_ready = !skid_valid, driven from a register with no combinational path from i_ready.
  - When the output drains and the skid is full, the skid moves to the output register in the same edge. The skid clears and o_ready rises next cycle.
- Simultaneous input fire and output drain with the skid empty: the new entry loads the output register directly. o_valid stays 1 and throughput is 1 per cycle.
- Ordering is strictly FIFO. Capacity is 2 entries.
- Inputs are ignored when !i_valid or !o_ready; no state change.
- Reset mid-operation discards all in-flight entries with no output handshake.

Decomposition:
- Shared package holds:
  - IMM_I=3'b000, IMM_S=3'b001, IMM_B=3'b010, IMM_J=3'b011, IMM_U=3'b100, IMM_Z=3'b101.
  - Entry struct {imm[XLEN-1:0], tag, illegal}.
- One sub-module, imm_decode: pure combinational, (instr, ImmSrc) -> (imm, illegal), parametrised by XLEN.
- The top holds the output register and the skid.

Test Plan:
- Format decode, XLEN=32, i_ready=1:
  - I: 0xFFF00093 -> 0xFFFFFFFF.
  - S: 0xFE20AE23 -> 0xFFFFFFFC.
  - J: 0xFFDFF06F -> 0xFFFFFFFC.
  - U: 0x123450B7 -> 0x12345000.
  - Z: 0x000FD073 -> 0x0000001F.
  - Each appears exactly 1 cycle after acceptance.
- XLEN=64:
  - U: 0x800000B7 -> 0xFFFFFFFF80000000.
  - B: 0x80000063 -> 0xFFFFFFFFFFFFF000.
- Illegal selector: ImmSrc=3'b110, tag=7 -> o_ImmExt=0, o_illegal=1, o_tag=7. The next legal entry has o_illegal=0.
- Backpressure:
  - Stream tags 1,2,3,4 with i_ready=0 for 3 cycles.
  - Output register holds 1 and the skid holds 2; o_ready=0 from the cycle after 2 is accepted.
  - Release i_ready: outputs appear 1,2,3,4 in order with no loss or duplication.
- Full throughput: i_valid and i_ready both high for 16 cycles -> 16 outputs on consecutive cycles, and o_ready stays 1.
- Reset mid-operation: with the skid full, pull i_rst_n low asynchronously mid-cycle. o_valid drops immediately and all outputs read 0. After release, the first new entry emerges with no stale data.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe_pkg
// Shared definitions for the pipelined immediate generator:
//   - immediate format selector codes (I, S, B, J, U, CSR zimm)
//   - helper functions for selector legality and XLEN legality
// The entry record (imm, tag, illegal) depends on the XLEN and TAG_WIDTH
// parameters, so it is declared in the top from these widths.
// -----------------------------------------------------------------------------
package imm_gen_pipe_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

    // Width of the raw immediate before extension: every format fits in 32 bits.
    localparam int RAW_W = 32;

    // Codes 110 and 111 are reserved.
    function automatic logic is_legal_src(input logic [2:0] src);
        logic legal;
        if (src <= IMM_Z) begin
            legal = 1'b1;
        end else begin
            legal = 1'b0;
        end
        return legal;
    endfunction

    // Only RV32 and RV64 widths are supported.
    function automatic bit xlen_ok(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
// Purely combinational immediate decoder.
// Ports:
//   instr_i    [31:0]      instruction word (bits [6:0] are not used)
//   imm_src_i  [2:0]       format selector
//   imm_o      [XLEN-1:0]  extended immediate (0 for reserved selectors)
//   illegal_o              selector was a reserved code
// -----------------------------------------------------------------------------
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [2:0]      imm_src_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    // Immediate assembled and extended to 32 bits first; the final step to
    // XLEN replicates bit 31, which equals instr[31] for sign-extended formats
    // and is 0 for zimm.
    logic signed [RAW_W-1:0] raw_s;
    logic                    unused_opcode_s;

    assign unused_opcode_s = ^instr_i[6:0];

    // Format-dependent bit gathering and 32-bit extension.
    always_comb begin
        raw_s = '0;
        case (imm_src_i)
            IMM_I: raw_s = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: raw_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: raw_s = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_J: raw_s = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            IMM_U: raw_s = {instr_i[31:12], 12'h000};
            IMM_Z: raw_s = {27'h0000000, instr_i[19:15]};
            default: raw_s = '0;
        endcase
    end

    assign imm_o     = XLEN'(raw_s);
    assign illegal_o = ~is_legal_src(imm_src_i);

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Pipelined immediate generator between decode and execute. Decodes the
// immediate of every RV32/RV64 base format, extends it to XLEN and carries a
// sideband tag. A one-entry skid buffer behind the output register absorbs
// backpressure so o_ready never depends combinationally on i_ready.
// Ports:
//   i_clk, i_rst_n       clock (rising edge), async active-low reset
//   i_valid / o_ready    input handshake (instruction, selector, tag)
//   i_instr [31:0]       instruction word
//   i_ImmSrc [2:0]       format selector
//   i_tag               sideband tag, passed through unchanged
//   o_valid / i_ready    output handshake
//   o_ImmExt [XLEN-1:0]  extended immediate
//   o_tag                tag belonging to o_ImmExt
//   o_illegal            selector was a reserved code
// -----------------------------------------------------------------------------
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [31:0]          i_instr,
    input  logic [2:0]           i_ImmSrc,
    input  logic [TAG_WIDTH-1:0] i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [XLEN-1:0]      o_ImmExt,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic                 o_illegal
);

    typedef struct packed {
        logic [XLEN-1:0]      imm;
        logic [TAG_WIDTH-1:0] tag;
        logic                 illegal;
    } entry_t;

    logic [XLEN-1:0] dec_imm_s;
    logic            dec_illegal_s;
    entry_t          new_s;
    logic            in_fire_s;
    logic            out_fire_s;

    entry_t out_q,  out_d;
    logic   out_valid_q,  out_valid_d;
    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   ready_q,      ready_d;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i   (i_instr),
        .imm_src_i (i_ImmSrc),
        .imm_o     (dec_imm_s),
        .illegal_o (dec_illegal_s)
    );

    assign in_fire_s  = i_valid & ready_q;
    assign out_fire_s = out_valid_q & i_ready;

    // Pack the decoded immediate with its sideband into one entry.
    always_comb begin
        new_s         = '0;
        new_s.imm     = dec_imm_s;
        new_s.tag     = i_tag;
        new_s.illegal = dec_illegal_s;
    end

    // Next-state for the output register and the skid entry.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || out_fire_s) begin
            // Output slot is free this edge: the older skid entry has
            // priority over the incoming one to keep FIFO order. While the
            // skid is full o_ready is low, so both cannot compete.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire_s) begin
                out_d       = new_s;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            // Output stalled: a newly accepted entry parks in the skid.
            if (in_fire_s) begin
                skid_d       = new_s;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
        // Registered ready: low exactly while the skid holds an entry.
        ready_d = ~skid_valid_d;
    end

    // State registers; reset clears everything and holds o_ready low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = out_valid_q;
    assign o_ImmExt  = out_q.imm;
    assign o_tag     = out_q.tag;
    assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Drives an XLEN=32 and an XLEN=64 instance with identical stimulus and
// compares both against a queue-based reference: a FIFO of capacity 2 whose
// entries are computed arithmetically from the immediate format rules.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;
    import imm_gen_pipe_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [4:0]  tag;

    logic        rdy32, rdy64, vld32, vld64, ill32, ill64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [4:0]  tag32, tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_WIDTH(5)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy32),
        .i_instr(instr), .i_ImmSrc(sel), .i_tag(tag), .o_valid(vld32),
        .i_ready(i_ready), .o_ImmExt(imm32), .o_tag(tag32), .o_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_WIDTH(5)) u_dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy64),
        .i_instr(instr), .i_ImmSrc(sel), .i_tag(tag), .o_valid(vld64),
        .i_ready(i_ready), .o_ImmExt(imm64), .o_tag(tag64), .o_illegal(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        ill;
    } ent_t;

    ent_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   started = 1'b0;
    bit   last_in_fire;
    bit   last_out_fire;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Reference immediate: field value interpreted as a two's complement
    // number of the format's width, using plain integer arithmetic.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] s);
        longint v;
        v = 0;
        case (s)
            3'd0: begin v = ins[31:20]; if (v >= 2048) v -= 4096; end
            3'd1: begin v = {ins[31:25], ins[11:7]}; if (v >= 2048) v -= 4096; end
            3'd2: begin
                v = {ins[31], ins[7], ins[30:25], ins[11:8]};
                v = v * 2;
                if (v >= 4096) v -= 8192;
            end
            3'd3: begin
                v = {ins[31], ins[19:12], ins[20], ins[30:21]};
                v = v * 2;
                if (v >= (longint'(1) << 20)) v -= (longint'(1) << 21);
            end
            3'd4: begin
                v = ins[31:12];
                v = v * 4096;
                if (v >= (longint'(1) << 31)) v -= (longint'(1) << 32);
            end
            3'd5: v = ins[19:15];
            default: v = 0;
        endcase
        return v;
    endfunction

    // One clock: check outputs mid-cycle against the model, then apply the
    // handshakes that fire on the coming rising edge.
    task automatic cycle();
        bit   exp_ready, exp_valid, in_f, out_f;
        ent_t e;
        @(negedge clk);
        exp_ready = started && (q.size() < 2);
        exp_valid = (q.size() > 0);
        chk("o_ready32", rdy32, exp_ready);
        chk("o_ready64", rdy64, exp_ready);
        chk("o_valid32", vld32, exp_valid);
        chk("o_valid64", vld64, exp_valid);
        if (exp_valid) begin
            chk("imm32", imm32, q[0].imm[31:0]);
            chk("imm64", imm64, q[0].imm);
            chk("tag32", tag32, q[0].tag);
            chk("tag64", tag64, q[0].tag);
            chk("ill32", ill32, q[0].ill);
            chk("ill64", ill64, q[0].ill);
        end
        in_f  = rst_n && i_valid && exp_ready;
        out_f = rst_n && exp_valid && i_ready;
        e.imm = ref_imm(instr, sel);
        e.tag = tag;
        e.ill = (sel > 3'd5);
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_f) void'(q.pop_front());
            if (in_f) q.push_back(e);
            started = 1'b1;
        end
        last_in_fire  = in_f;
        last_out_fire = out_f;
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [2:0] s, input logic [4:0] t);
        i_valid = 1'b1;
        i_ready = 1'b1;
        instr   = ins;
        sel     = s;
        tag     = t;
        cycle();
        i_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 10 && q.size() > 0; k++) cycle();
        chk(name, q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"}, {vld32, vld64}, 2'b00);
        chk({name, "_ready"}, {rdy32, rdy64}, 2'b00);
        chk({name, "_imm32"}, imm32, 64'h0);
        chk({name, "_imm64"}, imm64, 64'h0);
        chk({name, "_tag"}, {tag32, tag64}, 10'h000);
        chk({name, "_ill"}, {ill32, ill64}, 2'b00);
    endtask

    int idx;
    int cnt;

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        instr   = 32'h0;
        sel     = 3'd0;
        tag     = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        cycle();
        rst_n = 1'b1;
        cycle();

        // Directed format decode, one cycle after acceptance.
        send(32'hFFF00093, IMM_I, 5'd1); chk("dir_I", imm32, 64'hFFFF_FFFF);
        send(32'hFE20AE23, IMM_S, 5'd2); chk("dir_S", imm32, 64'hFFFF_FFFC);
        send(32'hFFDFF06F, IMM_J, 5'd3); chk("dir_J", imm32, 64'hFFFF_FFFC);
        send(32'h123450B7, IMM_U, 5'd4); chk("dir_U", imm32, 64'h1234_5000);
        send(32'h000FD073, IMM_Z, 5'd5); chk("dir_Z", imm32, 64'h0000_001F);
        send(32'h800000B7, IMM_U, 5'd6); chk("dir_U64", imm64, 64'hFFFF_FFFF_8000_0000);
        send(32'h80000063, IMM_B, 5'd7); chk("dir_B64", imm64, 64'hFFFF_FFFF_FFFF_F000);

        // Reserved selector followed by a legal entry.
        send(32'hFFFFFFFF, 3'b110, 5'd7);
        chk("ill_flag", {ill32, ill64}, 2'b11);
        chk("ill_imm", imm64, 64'h0);
        chk("ill_tag", tag32, 64'd7);
        send(32'h00100093, IMM_I, 5'd8);
        chk("legal_flag", {ill32, ill64}, 2'b00);
        drain("drain_dir");

        // Backpressure: tags 1..4 offered continuously, i_ready low 3 cycles.
        i_ready = 1'b0;
        idx = 1;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) i_ready = 1'b1;
            i_valid = (idx <= 4);
            tag     = 5'(idx);
            instr   = $urandom;
            sel     = IMM_I;
            cycle();
            if (last_in_fire) idx++;
        end
        chk("bp_all_accepted", idx, 5);
        drain("drain_bp");

        // Randomised traffic and backpressure.
        for (int c = 0; c < 400; c++) begin
            i_valid = ($urandom_range(3, 0) != 0);
            i_ready = ($urandom_range(2, 0) != 0);
            instr   = $urandom;
            sel     = 3'($urandom_range(7, 0));
            tag     = 5'($urandom);
            cycle();
        end
        drain("drain_rand");

        // Full throughput: 16 back-to-back entries.
        i_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 17; c++) begin
            i_valid = (c < 16);
            instr   = $urandom;
            sel     = 3'($urandom_range(5, 0));
            tag     = 5'(c);
            cycle();
            if (last_out_fire) cnt++;
        end
        chk("thru_count", cnt, 16);
        drain("drain_thru");

        // Reset in the middle of a cycle with the skid full.
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            instr = $urandom;
            sel   = IMM_S;
            tag   = 5'(20 + c);
            cycle();
        end
        chk("pre_rst_fill", q.size(), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        q.delete();
        started = 1'b0;
        i_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        send(32'h00500093, IMM_I, 5'd9);
        chk("post_rst_tag", tag32, 64'd9);
        chk("post_rst_imm", imm32, 64'd5);
        drain("drain_post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
